// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: W-bit add/subtract computed one N-bit ripple slice per cycle with a registered carry
module add_seq_ctrl #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         ovf,
  output logic         busy
);
  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic           ovf_q, ovf_d;
  logic           live_q, live_d;
  logic [N-1:0]   sa, sb, ssum;
  logic           cr;
  generate
    if (W % N != 0) begin : g_bad_width
      $error("add_seq_ctrl: W must be a multiple of N");
    end
  endgenerate
  assign in_ready  = live_q && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign s         = s_q;
  assign ovf       = ovf_q;
  // one N-bit ripple slice selected by idx, fed by the registered carry
  always_comb begin
    sa = a_q[idx_q*N +: N];
    sb = b_q[idx_q*N +: N];
    ssum = '0;
    cr = carry_q;
    for (int i = 0; i < N; i++) begin
      ssum[i] = (sa[i] ^ sb[i]) ^ cr;
      cr = (sa[i] & sb[i]) | ((sa[i] ^ sb[i]) & cr);
    end
  end
  // sequencing: accept in IDLE, one slice per RUN edge, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    live_d  = 1'b1;
    case (state_q)
      IDLE: if (in_ready && in_valid) begin
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub;
        idx_d   = '0;
        s_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        s_d[idx_q*N +: N] = ssum;
        carry_d = cr;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(K - 1)) begin
          ovf_d   = cr;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      live_q  <= live_d;
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scoreboard bench for the sliced add/subtract controller
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, ovf, busy;
  logic [15:0] s;
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, ovf1, busy1;
  logic [15:0] s1;
  int n_chk = 0, n_pass = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  add_seq_ctrl #(.N(4), .W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf), .busy(busy)
  );
  add_seq_ctrl #(.N(16), .W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .sub(1'b0), .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .ovf(ovf1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    return sv ? {1'b0, av} + {1'b0, ~bv} + 17'd1 : {1'b0, av} + {1'b0, bv};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
  endtask

  task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                    input int stall, input bit noisy);
    int cyc = 0;
    logic [16:0] e;
    logic [15:0] s_hold;
    logic        o_hold;
    wait_ready();
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    exp_q.push_back(model(av, bv, sv));
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      if (noisy) begin
        in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        if (in_ready) chk("in_ready_run", 32'(in_ready), 0);
      end
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, 4);
    s_hold = s; o_hold = ovf;
    for (int i = 0; i < stall; i++) begin
      if (noisy) begin
        in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      end
      @(posedge clk); #1;
      if (!out_valid || s !== s_hold || ovf !== o_hold || in_ready)
        chk("stall_hold", {out_valid, in_ready, ovf, 13'd0, s}, {1'b1, 1'b0, o_hold, 13'd0, s_hold});
    end
    if (stall > 0) chk("stall_end_valid", 32'(out_valid), 1);
    e = exp_q.pop_front();
    chk("sum", 32'(s), 32'(e[15:0]));
    chk("ovf", 32'(ovf), 32'(e[16]));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    #2;
    chk("rst_outs", {12'd0, in_ready, out_valid, busy, ovf, s}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(in_ready), 1);
    op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'h0005, 16'h0003, 1'b1, 0, 1'b0);
    op(16'h0003, 16'h0005, 1'b1, 0, 1'b0);
    op(16'h1357, 16'h2468, 1'b0, 10, 1'b1);
    op(16'h8000, 16'h0001, 1'b1, 3, 1'b1);
    // reset while idx=2
    wait_ready();
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_outs", {12'd0, in_ready, out_valid, busy, ovf, s}, 32'd0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("no_valid_after_rst", seen, 0);
    end
    op(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) op(16'($urandom), 16'($urandom), 1'($urandom), i, 1'b1);
    // single-slice instance
    a1 = 16'h8000; b1 = 16'h8000; in_valid1 = 1'b1;
    @(posedge clk); #1; in_valid1 = 1'b0;
    chk("k1_valid", 32'(out_valid1), 0);
    @(posedge clk); #1;
    chk("k1_lat", 32'(out_valid1), 1);
    chk("k1_sum", {15'd0, ovf1, s1}, 32'h10000);
    out_ready1 = 1'b1;
    @(posedge clk); #1; out_ready1 = 1'b0;
    chk("k1_hs", {30'd0, out_valid1, in_ready1}, 32'b01);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
